// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, states,
// datapath mux codes and the OpCode -> ALUOp table.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_MUL    = 6'h1c;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EX_R   = 4'd2,
        S_EX_I   = 4'd3,
        S_EX_MA  = 4'd4,
        S_EX_BR  = 4'd5,
        S_EX_J   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_R   = 4'd9,
        S_WB_I   = 4'd10,
        S_WB_LD  = 4'd11
    } state_t;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU control shared with the single-cycle decoder; bit 4 flags the
    // unsigned/odd variant of each opcode pair.
    function automatic logic [4:0] aluop_table(input logic [5:0] op);
        logic [3:0] low;
        case (op)
            OP_RTYPE:          low = 4'b0010;
            OP_BEQ:            low = 4'b0001;
            OP_ANDI:           low = 4'b0100;
            OP_SLTI, OP_SLTIU: low = 4'b0101;
            OP_MUL:            low = 4'b0111;
            OP_BNE:            low = 4'b0110;
            OP_ORI:            low = 4'b0011;
            OP_BLEZ:           low = 4'b1000;
            OP_BGTZ:           low = 4'b1001;
            OP_REGIMM:         low = 4'b1010;
            default:           low = 4'b0000;
        endcase
        return {op[0], low};
    endfunction

endpackage

// File: rtl/mc_aluop_decode.sv
// Combinational OpCode -> ALUOp decoder, shared with the single-cycle CPU.
module mc_aluop_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] op_code_i,
    output logic [4:0] alu_op_o
);

    assign alu_op_o = aluop_table(op_code_i);

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath. Outputs are decoded from
// the registered state, with the memory handshake qualifying the memory states.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic       LuOp,
    output logic [4:0] ALUOp,
    output logic [3:0] state_o,
    output logic       mem_err,
    output logic       illegal_op
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [4:0]       aluop_tbl;
    logic             mem_state;
    logic             timeout;

    mc_aluop_decode u_aluop (
        .op_code_i (OpCode),
        .alu_op_o  (aluop_tbl)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout   = mem_state && !mem_ready && (cnt_q == CNT_LAST);
    assign state_o   = state_q;
    assign mem_err   = mem_err_q && !reset;

    // State, wait counter and timeout flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state, wait-counter and per-state control strobes; reset forces strobes low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        mem_err_d   = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = REGDST_RT;
        MemtoReg    = M2R_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RT;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        ALUOp       = 5'b0;
        illegal_op  = 1'b0;

        if (mem_state && !mem_ready && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (OpCode)
                    OP_RTYPE:                               state_d = (Funct == FN_JR) ? S_EX_J : S_EX_R;
                    OP_LW, OP_SW:                           state_d = S_EX_MA;
                    OP_REGIMM, OP_BEQ, OP_BNE,
                    OP_BLEZ, OP_BGTZ:                       state_d = S_EX_BR;
                    OP_J, OP_JAL:                           state_d = S_EX_J;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_LUI, OP_MUL:        state_d = S_EX_I;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EX_R: begin
                ALUSrcA = (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA) ? SRCA_SHAMT : SRCA_RS;
                ALUSrcB = SRCB_RT;
                ALUOp   = aluop_tbl;
                state_d = S_WB_R;
            end
            S_EX_I: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = (OpCode == OP_MUL) ? SRCB_RT : SRCB_IMM;
                ExtOp   = (OpCode != OP_ANDI);
                LuOp    = (OpCode == OP_LUI);
                ALUOp   = aluop_tbl;
                state_d = S_WB_I;
            end
            S_EX_MA: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
                state_d = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_EX_BR: begin
                ALUSrcA     = SRCA_RS;
                ALUSrcB     = SRCB_RT;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                ALUOp       = aluop_tbl;
                state_d     = S_FETCH;
            end
            S_EX_J: begin
                PCWrite  = 1'b1;
                PCSource = (OpCode == OP_RTYPE && Funct == FN_JR) ? PCSRC_RS : PCSRC_JUMP;
                ALUOp    = aluop_tbl;
                if (OpCode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RA;
                    MemtoReg = M2R_PC;
                end
                state_d = S_FETCH;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_LD;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RD;
                state_d  = S_FETCH;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_MDR;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 2'b00;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ExtOp       = 1'b0;
            LuOp        = 1'b0;
            ALUOp       = 5'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each driven cycle pushes its
// hand-derived expected control word, a monitor pops and compares mid-cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic [1:0] PCSource;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegWrite;
        logic [1:0] RegDst;
        logic [1:0] MemtoReg;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ExtOp;
        logic       LuOp;
        logic [4:0] ALUOp;
        logic [3:0] state;
        logic       mem_err;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        string name;
        ctl_t  e;
    } item_t;

    localparam logic [3:0] ST_F = 4'd0, ST_D = 4'd1, ST_R = 4'd2, ST_I = 4'd3, ST_MA = 4'd4,
                           ST_BR = 4'd5, ST_J = 4'd6, ST_MRD = 4'd7, ST_MWR = 4'd8,
                           ST_WR = 4'd9, ST_WI = 4'd10, ST_WLD = 4'd11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = '0;
    logic [5:0] Funct = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic       ExtOp, LuOp, mem_err, illegal_op;
    logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
    logic [4:0] ALUOp;
    logic [3:0] state_o;

    item_t sbq[$];
    int    checks = 0;
    int    failures = 0;

    multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .LuOp(LuOp), .ALUOp(ALUOp), .state_o(state_o),
        .mem_err(mem_err), .illegal_op(illegal_op)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic ctl_t z(input logic [3:0] st);
        ctl_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic ctl_t fetchExp(input logic rdy, input logic err);
        ctl_t e;
        e = z(ST_F);
        e.MemRead = 1'b1;
        e.ALUSrcB = 2'b01;
        e.IRWrite = rdy;
        e.PCWrite = rdy;
        e.mem_err = err;
        return e;
    endfunction

    function automatic ctl_t decodeExp(input logic ill);
        ctl_t e;
        e = z(ST_D);
        e.ALUSrcB = 2'b11;
        e.illegal_op = ill;
        return e;
    endfunction

    function automatic ctl_t maExp();
        ctl_t e;
        e = z(ST_MA);
        e.ALUSrcA = 2'b01;
        e.ALUSrcB = 2'b10;
        e.ExtOp = 1'b1;
        return e;
    endfunction

    function automatic ctl_t wbExp(input logic [3:0] st, input logic [1:0] dst, input logic [1:0] m2r);
        ctl_t e;
        e = z(st);
        e.RegWrite = 1'b1;
        e.RegDst = dst;
        e.MemtoReg = m2r;
        return e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [5:0] op,
                                 input logic [5:0] fn, input string name, input ctl_t e);
        item_t it;
        @(negedge clk);
        reset = rst;
        mem_ready = rdy;
        OpCode = op;
        Funct = fn;
        it.name = name;
        it.e = e;
        sbq.push_back(it);
    endtask

    task automatic fetchDecode(input int waits, input logic [5:0] op, input logic [5:0] fn, input string name);
        for (int i = 0; i < waits; i++) applyStimulus(1'b0, 1'b0, op, fn, {name, "_fwait"}, fetchExp(1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1, op, fn, {name, "_fetch"}, fetchExp(1'b1, 1'b0));
        applyStimulus(1'b0, 1'b1, op, fn, {name, "_decode"}, decodeExp(1'b0));
    endtask

    task automatic checkOutput(input item_t it);
        ctl_t got;
        got = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp, ALUOp, state_o, mem_err, illegal_op};
        checks++;
        if (got !== it.e) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h (state got=%0d exp=%0d)",
                     it.name, got, it.e, got.state, it.e.state);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) checkOutput(sbq.pop_front());
        end
    end

    // Directed instruction sequences.
    initial begin
        ctl_t e;
        @(posedge clk);
        applyStimulus(1'b1, 1'b1, 6'h00, 6'h20, "reset0", z(ST_F));
        applyStimulus(1'b1, 1'b1, 6'h00, 6'h20, "reset1", z(ST_F));

        // add
        fetchDecode(0, 6'h00, 6'h20, "add");
        e = z(ST_R); e.ALUSrcA = 2'b01; e.ALUOp = 5'b00010;
        applyStimulus(1'b0, 1'b1, 6'h00, 6'h20, "add_ex", e);
        applyStimulus(1'b0, 1'b0, 6'h00, 6'h20, "add_wb", wbExp(ST_WR, 2'b01, 2'b00));

        // lw: 3 waits in FETCH, ready on 2nd MEM_RD cycle -> 9 cycles
        fetchDecode(3, 6'h23, 6'h00, "lw");
        applyStimulus(1'b0, 1'b0, 6'h23, 6'h00, "lw_ma", maExp());
        e = z(ST_MRD); e.MemRead = 1'b1; e.IorD = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h23, 6'h00, "lw_mrd0", e);
        applyStimulus(1'b0, 1'b1, 6'h23, 6'h00, "lw_mrd1", e);
        applyStimulus(1'b0, 1'b1, 6'h23, 6'h00, "lw_wb", wbExp(ST_WLD, 2'b00, 2'b01));

        // beq
        fetchDecode(0, 6'h04, 6'h00, "beq");
        e = z(ST_BR); e.ALUSrcA = 2'b01; e.PCWriteCond = 1'b1; e.PCSource = 2'b01; e.ALUOp = 5'b00001;
        applyStimulus(1'b0, 1'b1, 6'h04, 6'h00, "beq_ex", e);

        // jal
        fetchDecode(0, 6'h03, 6'h00, "jal");
        e = z(ST_J); e.PCWrite = 1'b1; e.PCSource = 2'b10; e.RegWrite = 1'b1;
        e.RegDst = 2'b10; e.MemtoReg = 2'b10; e.ALUOp = 5'b10000;
        applyStimulus(1'b0, 1'b0, 6'h03, 6'h00, "jal_ex", e);

        // jr
        fetchDecode(0, 6'h00, 6'h08, "jr");
        e = z(ST_J); e.PCWrite = 1'b1; e.PCSource = 2'b11; e.ALUOp = 5'b00010;
        applyStimulus(1'b0, 1'b0, 6'h00, 6'h08, "jr_ex", e);

        // andi: zero-extend
        fetchDecode(0, 6'h0c, 6'h00, "andi");
        e = z(ST_I); e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.ALUOp = 5'b00100;
        applyStimulus(1'b0, 1'b0, 6'h0c, 6'h00, "andi_ex", e);
        applyStimulus(1'b0, 1'b0, 6'h0c, 6'h00, "andi_wb", wbExp(ST_WI, 2'b00, 2'b00));

        // lui
        fetchDecode(0, 6'h0f, 6'h00, "lui");
        e = z(ST_I); e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.ExtOp = 1'b1; e.LuOp = 1'b1; e.ALUOp = 5'b10000;
        applyStimulus(1'b0, 1'b0, 6'h0f, 6'h00, "lui_ex", e);
        applyStimulus(1'b0, 1'b0, 6'h0f, 6'h00, "lui_wb", wbExp(ST_WI, 2'b00, 2'b00));

        // sll: shamt as ALU A operand
        fetchDecode(0, 6'h00, 6'h00, "sll");
        e = z(ST_R); e.ALUSrcA = 2'b10; e.ALUOp = 5'b00010;
        applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, "sll_ex", e);
        applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, "sll_wb", wbExp(ST_WR, 2'b01, 2'b00));

        // sw with mem_ready held low: 15 MEM_WR cycles then mem_err in FETCH
        fetchDecode(0, 6'h2b, 6'h00, "swto");
        applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swto_ma", maExp());
        e = z(ST_MWR); e.MemWrite = 1'b1; e.IorD = 1'b1;
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swto_mwr", e);
        applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swto_err", fetchExp(1'b0, 1'b1));

        // sw with ready arriving on the timeout cycle: ready wins, no mem_err
        fetchDecode(0, 6'h2b, 6'h00, "swrw");
        applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swrw_ma", maExp());
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swrw_mwr", e);
        applyStimulus(1'b0, 1'b1, 6'h2b, 6'h00, "swrw_last", e);

        // illegal opcode
        applyStimulus(1'b0, 1'b1, 6'h3f, 6'h00, "ill_fetch", fetchExp(1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 6'h3f, 6'h00, "ill_decode", decodeExp(1'b1));

        // reset asserted while in MEM_WR
        fetchDecode(0, 6'h2b, 6'h00, "swrst");
        applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swrst_ma", maExp());
        applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swrst_mwr", e);
        applyStimulus(1'b1, 1'b0, 6'h2b, 6'h00, "swrst_rst", z(ST_MWR));
        applyStimulus(1'b0, 1'b0, 6'h2b, 6'h00, "swrst_after", fetchExp(1'b0, 1'b0));

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
